// File: rtl/exc_arbiter_pkg.sv
// Shared types and constants for the exception arbiter.
// Exception codes follow the MIPS Cause.ExcCode field plus two private codes.
package exc_arbiter_pkg;

  localparam int EXC_CODE_WIDTH = 5;
  localparam int INT_MASK_WIDTH = 8;
  localparam int NSTAGE = 4;

  typedef logic [EXC_CODE_WIDTH-1:0] exc_code_t;

  localparam exc_code_t EC_INT  = 5'd0;
  localparam exc_code_t EC_MOD  = 5'd1;
  localparam exc_code_t EC_TLBL = 5'd2;
  localparam exc_code_t EC_TLBS = 5'd3;
  localparam exc_code_t EC_ADEL = 5'd4;
  localparam exc_code_t EC_ADES = 5'd5;
  localparam exc_code_t EC_SYS  = 5'd8;
  localparam exc_code_t EC_BP   = 5'd9;
  localparam exc_code_t EC_RI   = 5'd10;
  localparam exc_code_t EC_OV   = 5'd12;
  // Not architectural codes; never written into Cause.
  localparam exc_code_t EC_ERET = 5'h1e;
  localparam exc_code_t EC_NONE = 5'h1f;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    return bd ? pc - 32'd4 : pc;
  endfunction

  // Winner plus every younger stage.
  function automatic logic [NSTAGE-1:0] flush_mask(
    input logic [1:0] w
  );
    logic [NSTAGE-1:0] m;
    for (int i = 0; i < NSTAGE; i++)
      m[i] = (i <= int'(w));
    return m;
  endfunction

endpackage

// File: rtl/exc_arbiter_if.sv
// Stage request bus and cp0 exception bus around the arbiter.
// The slave side is the arbiter; the master side is pipeline plus cp0.
interface exc_arbiter_if;
  import exc_arbiter_pkg::*;

  logic [NSTAGE-1:0]             stg_valid;
  exc_code_t [NSTAGE-1:0]        stg_exc_code;
  logic [NSTAGE-1:0][31:0]       stg_pc;
  logic [NSTAGE-1:0][31:0]       stg_badvaddr;
  logic [NSTAGE-1:0]             stg_bd;
  logic                          status_ie;
  logic                          status_exl;
  logic [INT_MASK_WIDTH-1:0]     status_im;
  logic [INT_MASK_WIDTH-1:0]     cause_ip;
  logic                          exc_jmp_flag;
  exc_code_t                     exc_code;
  logic [31:0]                   exc_epc;
  logic [31:0]                   exc_badvaddr;
  logic [NSTAGE-1:0]             flush;
  logic                          busy;
  logic                          err;

  modport master (
    output stg_valid, stg_exc_code, stg_pc,
    output stg_badvaddr, stg_bd,
    output status_ie, status_exl, status_im,
    output cause_ip, exc_jmp_flag,
    input  exc_code, exc_epc, exc_badvaddr,
    input  flush, busy, err
  );

  modport slave (
    input  stg_valid, stg_exc_code, stg_pc,
    input  stg_badvaddr, stg_bd,
    input  status_ie, status_exl, status_im,
    input  cause_ip, exc_jmp_flag,
    output exc_code, exc_epc, exc_badvaddr,
    output flush, busy, err
  );

endinterface

// File: rtl/exc_prio_sel.sv
// Precise-exception priority: interrupt, then oldest stage (MEM) down to IF.
// int_pend must already be qualified by a live MEM instruction.
module exc_prio_sel
  import exc_arbiter_pkg::*;
(
  input  logic [NSTAGE-1:0] req,
  input  logic              int_pend,
  output logic [1:0]        win,
  output logic              win_int,
  output logic              win_vld
);

  always_comb begin
    win     = 2'd0;
    win_int = 1'b0;
    win_vld = 1'b1;
    if (int_pend) begin
      win     = 2'd3;
      win_int = 1'b1;
    end else if (req[3]) begin
      win = 2'd3;
    end else if (req[2]) begin
      win = 2'd2;
    end else if (req[1]) begin
      win = 2'd1;
    end else if (req[0]) begin
      win = 2'd0;
    end else begin
      win_vld = 1'b0;
    end
  end

endmodule

// File: rtl/exc_arbiter.sv
// Picks one exception/interrupt, hands it to cp0 for a single cycle and
// holds the pipeline flushed until cp0 reports the vector jump.
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter int JMP_TIMEOUT = 4
) (
  input logic         clk,
  input logic         rst,
  exc_arbiter_if.slave bus
);

  localparam int CW = $clog2(JMP_TIMEOUT + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  exc_code_t         code_q;
  logic [31:0]       epc_q;
  logic [31:0]       bad_q;
  logic [NSTAGE-1:0] flush_q;
  logic              busy_q;
  logic              err_q;

  logic [NSTAGE-1:0] req;
  logic              int_pend;
  logic [1:0]        win;
  logic              win_int;
  logic              win_vld;

  always_comb begin
    req = '0;
    for (int i = 0; i < NSTAGE; i++)
      req[i] = bus.stg_valid[i] &&
               (bus.stg_exc_code[i] != EC_NONE);
  end

  assign int_pend = bus.status_ie & ~bus.status_exl
                  & |(bus.cause_ip & bus.status_im)
                  & bus.stg_valid[3];

  exc_prio_sel u_sel (
    .req      (req),
    .int_pend (int_pend),
    .win      (win),
    .win_int  (win_int),
    .win_vld  (win_vld)
  );

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      code_q  <= EC_NONE;
      epc_q   <= '0;
      bad_q   <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state   <= ST_ISSUE;
            code_q  <= win_int ? EC_INT
                               : bus.stg_exc_code[win];
            epc_q   <= epc_of(bus.stg_pc[win],
                              bus.stg_bd[win]);
            bad_q   <= bus.stg_badvaddr[win];
            flush_q <= flush_mask(win);
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state  <= ST_WAIT;
          code_q <= EC_NONE;
          cnt    <= '0;
        end
        ST_WAIT: begin
          if (bus.exc_jmp_flag) begin
            state   <= ST_IDLE;
            flush_q <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_inc == CW'(JMP_TIMEOUT)) begin
            state   <= ST_IDLE;
            flush_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.exc_code     = code_q;
  assign bus.exc_epc      = epc_q;
  assign bus.exc_badvaddr = bad_q;
  assign bus.flush        = flush_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: directed scenarios plus randomized requests
// checked against a priority-rule model of the arbiter.
module tb_exc_arbiter;
  import exc_arbiter_pkg::*;

  localparam int JT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  exc_arbiter_if bus ();

  exc_arbiter #(.JMP_TIMEOUT(JT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.stg_valid    = '0;
    bus.stg_bd       = '0;
    bus.status_ie    = 1'b0;
    bus.status_exl   = 1'b0;
    bus.status_im    = '0;
    bus.cause_ip     = '0;
    bus.exc_jmp_flag = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      bus.stg_exc_code[i] = EC_NONE;
      bus.stg_pc[i]       = 32'h0;
      bus.stg_badvaddr[i] = 32'h0;
    end
  endtask

  task automatic set_req(input int i, input exc_code_t c,
                         input logic [31:0] pc, input logic bd,
                         input logic [31:0] bv);
    bus.stg_exc_code[i] = c;
    bus.stg_pc[i]       = pc;
    bus.stg_bd[i]       = bd;
    bus.stg_badvaddr[i] = bv;
  endtask

  task automatic ack();
    bus.exc_jmp_flag = 1'b1;
    step();
    bus.exc_jmp_flag = 1'b0;
  endtask

  // Oldest requesting stage wins; interrupt beats all when MEM is live.
  function automatic void model(output logic vld, output exc_code_t c,
                                output logic [31:0] epc,
                                output logic [31:0] bv,
                                output logic [3:0] fl);
    int   w;
    logic irq;
    w   = -1;
    irq = bus.status_ie && !bus.status_exl && bus.stg_valid[3] &&
          ((bus.cause_ip & bus.status_im) != 0);
    vld = 1'b0;
    c   = EC_NONE;
    epc = 32'h0;
    bv  = 32'h0;
    fl  = 4'h0;
    if (irq) begin
      w = 3;
      c = EC_INT;
    end else begin
      for (int i = 0; i < NSTAGE; i++)
        if (bus.stg_valid[i] && bus.stg_exc_code[i] != EC_NONE)
          w = i;
    end
    if (w >= 0) begin
      vld = 1'b1;
      if (!irq) c = bus.stg_exc_code[w];
      epc = bus.stg_pc[w] - (bus.stg_bd[w] ? 32'd4 : 32'd0);
      bv  = bus.stg_badvaddr[w];
      fl  = 4'((1 << (w + 1)) - 1);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.exc_badvaddr} !==
        {EC_NONE, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h/%h want %h/0/0",
               bus.exc_code, bus.exc_epc, bus.exc_badvaddr, EC_NONE);
    end
    n_checks++;
    if ({bus.flush, bus.busy, bus.err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: flush/busy/err got %b/%b/%b want 0",
               bus.flush, bus.busy, bus.err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ex_overflow();
    clear_reqs();
    bus.stg_valid = 4'b1111;
    set_req(2, EC_OV, 32'h8000_1000, 1'b0, 32'h0);
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.flush, bus.busy} !==
        {EC_OV, 32'h8000_1000, 4'b0111, 1'b1}) begin
      n_fail++;
      $display("FAIL ex_ov_issue: got %h/%h/%b/%b want %h/80001000/0111/1",
               bus.exc_code, bus.exc_epc, bus.flush, bus.busy, EC_OV);
    end
    clear_reqs();
    step();
    n_checks++;
    if ({bus.exc_code, bus.flush, bus.busy} !==
        {EC_NONE, 4'b0111, 1'b1}) begin
      n_fail++;
      $display("FAIL ex_ov_wait: got %h/%b/%b want %h/0111/1",
               bus.exc_code, bus.flush, bus.busy, EC_NONE);
    end
    ack();
    n_checks++;
    if ({bus.flush, bus.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL ex_ov_done: flush/busy got %b/%b want 0/0",
               bus.flush, bus.busy);
    end
  endtask

  task automatic test_mem_vs_if();
    clear_reqs();
    bus.stg_valid = 4'b1111;
    set_req(3, EC_TLBS, 32'h8000_0100, 1'b0, 32'h0040_0004);
    set_req(0, EC_TLBL, 32'h8000_010c, 1'b0, 32'h1234_5678);
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_badvaddr, bus.flush} !==
        {EC_TLBS, 32'h0040_0004, 4'b1111}) begin
      n_fail++;
      $display("FAIL mem_vs_if: got %h/%h/%b want %h/00400004/1111",
               bus.exc_code, bus.exc_badvaddr, bus.flush, EC_TLBS);
    end
    clear_reqs();
    step();
    ack();
  endtask

  task automatic test_delay_slot();
    clear_reqs();
    bus.stg_valid = 4'b0011;
    set_req(1, EC_SYS, 32'h8000_0010, 1'b1, 32'h0);
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.flush} !==
        {EC_SYS, 32'h8000_000c, 4'b0011}) begin
      n_fail++;
      $display("FAIL delay_slot: got %h/%h/%b want %h/8000000c/0011",
               bus.exc_code, bus.exc_epc, bus.flush, EC_SYS);
    end
    clear_reqs();
    step();
    ack();
    bus.stg_valid = 4'b0001;
    set_req(0, EC_ADEL, 32'h0, 1'b1, 32'h0000_0003);
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.exc_badvaddr, bus.flush} !==
        {EC_ADEL, 32'hffff_fffc, 32'h0000_0003, 4'b0001}) begin
      n_fail++;
      $display("FAIL epc_wrap: got %h/%h/%h/%b want %h/fffffffc/3/0001",
               bus.exc_code, bus.exc_epc, bus.exc_badvaddr, bus.flush,
               EC_ADEL);
    end
    clear_reqs();
    step();
    ack();
  endtask

  task automatic test_interrupt(input logic exl);
    exc_code_t   want_c;
    logic [31:0] want_epc;
    logic [3:0]  want_fl;
    clear_reqs();
    bus.stg_valid  = 4'b1111;
    bus.cause_ip   = 8'h80;
    bus.status_im  = 8'h80;
    bus.status_ie  = 1'b1;
    bus.status_exl = exl;
    set_req(3, EC_NONE, 32'h8000_2000, 1'b0, 32'h0);
    set_req(2, EC_RI, 32'h8000_1ff0, 1'b0, 32'h0);
    want_c   = exl ? EC_RI : EC_INT;
    want_epc = exl ? 32'h8000_1ff0 : 32'h8000_2000;
    want_fl  = exl ? 4'b0111 : 4'b1111;
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.flush} !==
        {want_c, want_epc, want_fl}) begin
      n_fail++;
      $display("FAIL interrupt_exl%0d: got %h/%h/%b want %h/%h/%b",
               exl, bus.exc_code, bus.exc_epc, bus.flush,
               want_c, want_epc, want_fl);
    end
    clear_reqs();
    step();
    ack();
  endtask

  task automatic test_timeout();
    clear_reqs();
    bus.stg_valid = 4'b0100;
    set_req(2, EC_BP, 32'h8000_3000, 1'b0, 32'h0);
    step();
    clear_reqs();
    for (int k = 0; k < JT; k++) begin
      step();
      n_checks++;
      if ({bus.busy, bus.err, bus.flush} !== {1'b1, 1'b0, 4'b0111}) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: busy/err/flush got %b/%b/%b want 1/0/0111",
                 k, bus.busy, bus.err, bus.flush);
      end
    end
    step();
    n_checks++;
    if ({bus.busy, bus.err, bus.flush} !== {1'b0, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL timeout_hit: busy/err/flush got %b/%b/%b want 0/1/0000",
               bus.busy, bus.err, bus.flush);
    end
    step();
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", bus.err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", bus.err);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_reqs();
    bus.stg_valid = 4'b1000;
    set_req(3, EC_OV, 32'h8000_4000, 1'b0, 32'h0);
    step();
    clear_reqs();
    step();
    rst = 1'b1;
    bus.stg_valid = 4'b0011;
    set_req(1, EC_ERET, 32'h8000_5000, 1'b0, 32'h0);
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.flush, bus.busy, bus.err} !==
        {EC_NONE, 32'h0, 4'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_wait: got %h/%h/%b/%b/%b want %h/0/0/0/0",
               bus.exc_code, bus.exc_epc, bus.flush, bus.busy, bus.err,
               EC_NONE);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({bus.exc_code, bus.exc_epc, bus.flush} !==
        {EC_ERET, 32'h8000_5000, 4'b0011}) begin
      n_fail++;
      $display("FAIL eret_after_rst: got %h/%h/%b want %h/80005000/0011",
               bus.exc_code, bus.exc_epc, bus.flush, EC_ERET);
    end
    clear_reqs();
    step();
    ack();
  endtask

  task automatic test_random();
    exc_code_t   pool [10];
    logic        vld;
    exc_code_t   c;
    logic [31:0] epc;
    logic [31:0] bv;
    logic [3:0]  fl;
    logic        early;
    pool = '{EC_NONE, EC_NONE, EC_OV, EC_RI, EC_SYS,
             EC_TLBL, EC_TLBS, EC_ADEL, EC_ERET, EC_BP};
    for (int it = 0; it < 40; it++) begin
      clear_reqs();
      bus.stg_valid  = 4'($urandom);
      bus.status_ie  = 1'($urandom);
      bus.status_exl = 1'($urandom);
      bus.status_im  = 8'($urandom);
      bus.cause_ip   = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < NSTAGE; i++)
        set_req(i, pool[$urandom_range(0, 9)], $urandom,
                1'($urandom), $urandom);
      early = 1'($urandom);
      bus.exc_jmp_flag = early;
      model(vld, c, epc, bv, fl);
      step();
      bus.exc_jmp_flag = 1'b0;
      n_checks++;
      if ({bus.exc_code, bus.exc_epc, bus.exc_badvaddr,
           bus.flush, bus.busy} !==
          {c, vld ? epc : bus.exc_epc, vld ? bv : bus.exc_badvaddr,
           fl, vld}) begin
        n_fail++;
        $display("FAIL rand%0d_issue: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                 it, bus.exc_code, bus.exc_epc, bus.exc_badvaddr,
                 bus.flush, bus.busy, c, epc, bv, fl, vld);
      end
      if (vld) begin
        clear_reqs();
        bus.exc_jmp_flag = 1'($urandom);
        step();
        bus.exc_jmp_flag = 1'b0;
        n_checks++;
        if ({bus.exc_code, bus.flush, bus.busy} !== {EC_NONE, fl, 1'b1}) begin
          n_fail++;
          $display("FAIL rand%0d_wait: got %h/%b/%b want %h/%b/1",
                   it, bus.exc_code, bus.flush, bus.busy, EC_NONE, fl);
        end
        ack();
        n_checks++;
        if ({bus.flush, bus.busy, bus.err} !== 6'b0) begin
          n_fail++;
          $display("FAIL rand%0d_done: flush/busy/err got %b/%b/%b want 0",
                   it, bus.flush, bus.busy, bus.err);
        end
      end
    end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_ex_overflow();
    test_mem_vs_if();
    test_delay_slot();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
